// File: rtl/lsq_sched_pkg.sv
// ============================================================================
// lsq_sched_pkg : shared state encoding, size codes and width defaults for
//                 the LSQ memory scheduler.
// Revision 1.0
// ============================================================================
`default_nettype none

package lsq_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } sched_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int TAG_W_DEF        = 6;
    localparam int ST_HI_WM_DEF     = 4;
    localparam int STARVE_LIMIT_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/sched_starve_ctr.sv
// ============================================================================
// sched_starve_ctr : saturating count of cycles a store was refused, with
//                    synchronous clear and a limit-reached flag.
// Revision 1.0
// ============================================================================
`default_nettype none

module sched_starve_ctr
    import lsq_sched_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !full) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign full = (cnt >= CNT_W'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/lsq_mem_scheduler.sv
// ============================================================================
// lsq_mem_scheduler : single-outstanding data-memory sequencer for the LSQ.
//                     Optional SCHED_PERF_CNT_EN adds load/store/stall counters.
// Revision 1.0
// ============================================================================
`default_nettype none

module lsq_mem_scheduler
    import lsq_sched_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int TAG_W        = TAG_W_DEF,
    parameter int ST_HI_WM     = ST_HI_WM_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]       perf_ld_cnt,
    output logic [31:0]       perf_st_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    input  logic [3:0]        st_pending_cnt,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [DATA_W-1:0] ld_resp_data,
    output logic              st_done,
    output logic              busy
);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [TAG_W-1:0] tag_q;
    logic             kill_q;
    logic             starve_full;
    logic             store_pri;
    logic             ld_acc;
    logic             st_acc;
    logic             ld_kill_now;

    sched_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc  (st_valid && !st_acc),
        .clr  (st_acc),
        .full (starve_full)
    );

    assign store_pri   = (st_pending_cnt >= 4'(ST_HI_WM)) || starve_full;
    assign ld_kill_now = flush && !mem_we;

    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        st_ready = 1'b0;
        ld_acc   = 1'b0;
        st_acc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flushed load is not a competitor, so a lone store still wins.
                st_ready = st_valid && (store_pri || !(ld_valid && !flush));
                ld_ready = ld_valid && !flush && !st_ready;
                ld_acc   = ld_valid && ld_ready;
                st_acc   = st_valid && st_ready;
                if (ld_acc || st_acc) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_WAIT;
                end else if (ld_kill_now) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_size      <= 2'b00;
            tag_q         <= '0;
            kill_q        <= 1'b0;
            ld_resp_valid <= 1'b0;
            ld_resp_tag   <= '0;
            ld_resp_data  <= '0;
            st_done       <= 1'b0;
        end else begin
            ld_resp_valid <= 1'b0;
            st_done       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (st_acc) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= st_addr;
                        mem_wdata <= st_data;
                        mem_size  <= st_size;
                    end else if (ld_acc) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= ld_addr;
                        mem_wdata <= '0;
                        mem_size  <= ld_size;
                        tag_q     <= ld_tag;
                    end
                end
                S_REQ: begin
                    // Granted in the flush cycle: the access proceeds, its data is dropped.
                    if (ld_kill_now && mem_gnt) begin
                        kill_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        kill_q <= 1'b0;
                        if (mem_we) begin
                            st_done <= 1'b1;
                        end else if (!kill_q && !flush) begin
                            ld_resp_valid <= 1'b1;
                            ld_resp_tag   <= tag_q;
                            ld_resp_data  <= mem_rdata;
                        end
                    end else if (ld_kill_now) begin
                        kill_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req = (state_q == S_REQ);
    assign busy    = (state_q != S_IDLE);

`ifdef SCHED_PERF_CNT_EN
    logic ld_complete;
    logic st_complete;
    logic stalled;

    assign ld_complete = (state_q == S_WAIT) && mem_rvalid && !mem_we && !kill_q && !flush;
    assign st_complete = (state_q == S_WAIT) && mem_rvalid && mem_we;
    assign stalled     = (ld_valid || st_valid) && !(ld_acc || st_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ld_cnt    <= '0;
            perf_st_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (ld_complete) perf_ld_cnt    <= perf_ld_cnt + 32'd1;
            if (st_complete) perf_st_cnt    <= perf_st_cnt + 32'd1;
            if (stalled)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsq_mem_scheduler.sv
// ============================================================================
// tb_lsq_mem_scheduler : directed vector table for arbitration plus hand-made
//                        sequences for latency, starvation, flush and reset.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lsq_mem_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_valid, ld_ready, st_valid, st_ready, flush;
    logic [31:0] ld_addr, st_addr, st_data;
    logic [1:0]  ld_size, st_size;
    logic [5:0]  ld_tag;
    logic [3:0]  st_pending_cnt;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        ld_resp_valid, st_done, busy;
    logic [5:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_ld_cnt, perf_st_cnt, perf_stall_cnt;
`endif

    lsq_mem_scheduler dut (
        .clk            (clk),
        .rst            (rst),
`ifdef SCHED_PERF_CNT_EN
        .perf_ld_cnt    (perf_ld_cnt),
        .perf_st_cnt    (perf_st_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_size        (ld_size),
        .ld_tag         (ld_tag),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_size        (st_size),
        .st_pending_cnt (st_pending_cnt),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_size       (mem_size),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_tag    (ld_resp_tag),
        .ld_resp_data   (ld_resp_data),
        .st_done        (st_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic       sv;
        logic       fl;
        logic [3:0] pend;
        logic       exp_lr;
        logic       exp_sr;
    } arb_vec_t;

    arb_vec_t tbl[9];
    int n_vec  = 0;
    int n_miss = 0;
    int exp_ld = 0;
    int exp_st = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with mem_req visible; grants after gnt_wait idle cycles,
    // completes the next cycle and returns at the negedge where the response is visible.
    task automatic serve(input int gnt_wait, input logic [31:0] rdata);
        repeat (gnt_wait) @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ld_valid = 0; st_valid = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0;
        ld_addr = 0; ld_size = 0; ld_tag = 0; st_addr = 0; st_data = 0; st_size = 0;
        st_pending_cnt = 0; mem_rdata = 0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 4'd2,  1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'd4,  1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ld_resp_valid", ld_resp_valid, 0);
        check("rst_st_done", st_done, 0);
        rst = 1'b1;

        // Arbitration table: valids dropped before the edge so nothing is accepted.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ld_valid = tbl[i].lv; st_valid = tbl[i].sv; flush = tbl[i].fl;
            st_pending_cnt = tbl[i].pend;
            #1;
            check($sformatf("arb_vec%0d", i), {busy, ld_ready, st_ready}, {1'b0, tbl[i].exp_lr, tbl[i].exp_sr});
            #1;
            ld_valid = 0; st_valid = 0; flush = 0; st_pending_cnt = 0;
        end

        // Asynchronous reset while a load waits for its data
        @(negedge clk);
        ld_valid = 1; ld_addr = 32'h200; ld_tag = 6'd3; ld_size = 2'b10;
        @(negedge clk);
        ld_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        check("rstw_busy_before", busy, 1);
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_mem_req", mem_req, 0);
        check("rstw_ld_resp_valid", ld_resp_valid, 0);
        @(negedge clk);
        mem_rvalid = 0;
        check("rstw_no_resp", ld_resp_valid, 0);
        rst = 1; ld_valid = 1;
        #1;
        check("rstw_ld_ready", ld_ready, 1);
        #1;
        ld_valid = 0;

        // Basic load latency
        @(negedge clk);
        ld_valid = 1; ld_addr = 32'h100; ld_tag = 6'd5; ld_size = 2'b10;
        #1;
        check("ld_ready", ld_ready, 1);
        @(negedge clk);
        ld_valid = 0;
        check("ld_mem_req_n1", {mem_req, mem_we}, 2'b10);
        check("ld_mem_addr", mem_addr, 32'h100);
        @(negedge clk);
        check("ld_mem_req_n2", mem_req, 1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        check("ld_wait_n3", {mem_req, busy}, 2'b01);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_rvalid = 0;
        check("ld_resp_valid_n5", {ld_resp_valid, busy}, 2'b10);
        check("ld_resp_tag", ld_resp_tag, 6'd5);
        check("ld_resp_data", ld_resp_data, 32'hDEADBEEF);
        exp_ld++;
        @(negedge clk);
        check("ld_resp_pulse", ld_resp_valid, 0);

        // Watermark arbitration
        ld_valid = 1; st_valid = 1; st_pending_cnt = 2;
        ld_addr = 32'h300; ld_tag = 6'd7; st_addr = 32'h400; st_data = 32'hA5A5_0001; st_size = 2'b01;
        #1;
        check("wm2_ready", {ld_ready, st_ready}, 2'b10);
        @(negedge clk);
        ld_valid = 0; st_valid = 0;
        check("wm2_mem", {mem_we, mem_addr}, {1'b0, 32'h300});
        serve(1, 32'hCAFE0001);
        check("wm2_resp", {ld_resp_valid, ld_resp_tag, ld_resp_data}, {1'b1, 6'd7, 32'hCAFE0001});
        exp_ld++;
        ld_valid = 1; st_valid = 1; st_pending_cnt = 4;
        #1;
        check("wm4_ready", {ld_ready, st_ready}, 2'b01);
        @(negedge clk);
        ld_valid = 0; st_valid = 0;
        check("wm4_mem", {mem_we, mem_size, mem_addr}, {1'b1, 2'b01, 32'h400});
        check("wm4_wdata", mem_wdata, 32'hA5A5_0001);
        serve(0, 32'hFFFF_FFFF);
        check("wm4_done", {st_done, ld_resp_valid}, 2'b10);
        exp_st++;

        // Starvation: each 3-cycle load adds 3 refusals, so the limit of 8 is met
        // before the fourth arbitration.
        @(negedge clk);
        ld_valid = 1; st_valid = 1; st_pending_cnt = 1;
        st_addr = 32'h500; st_data = 32'h0BAD_F00D; st_size = 2'b10;
        for (int k = 0; k < 4; k++) begin
            ld_tag = 6'(10 + k); ld_addr = 32'h600 + 32'(k);
            #1;
            check($sformatf("starve_arb%0d", k), {ld_ready, st_ready}, {k < 3, k == 3});
            @(negedge clk);
            if (k < 3) begin
                check($sformatf("starve_ld%0d_we", k), mem_we, 0);
                serve(0, 32'h1000 + 32'(k));
                check($sformatf("starve_ld%0d_resp", k), {ld_resp_valid, ld_resp_tag}, {1'b1, 6'(10 + k)});
                exp_ld++;
            end else begin
                ld_valid = 0; st_valid = 0;
                check("starve_st_mem", {mem_we, mem_addr}, {1'b1, 32'h500});
                serve(0, 32'h0);
                check("starve_st_done", st_done, 1);
                exp_st++;
            end
        end
        ld_valid = 1; st_valid = 1; st_pending_cnt = 1;
        #1;
        check("starve_cleared", {ld_ready, st_ready}, 2'b10);
        #1;
        ld_valid = 0; st_valid = 0; st_pending_cnt = 0;

        // Flush in REQ without grant
        @(negedge clk);
        ld_valid = 1; ld_addr = 32'h700; ld_tag = 6'd20;
        @(negedge clk);
        ld_valid = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        check("flreq_idle", {mem_req, busy}, 2'b00);

        // Flush in WAIT
        ld_valid = 1; ld_addr = 32'h710; ld_tag = 6'd21;
        @(negedge clk);
        ld_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; flush = 1;
        @(negedge clk);
        flush = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 0;
        check("flwait_no_resp", {ld_resp_valid, busy}, 2'b00);

        // Flush coinciding with grant
        ld_valid = 1; ld_addr = 32'h720; ld_tag = 6'd22;
        @(negedge clk);
        ld_valid = 0; mem_gnt = 1; flush = 1;
        @(negedge clk);
        mem_gnt = 0; flush = 0;
        check("flgnt_still_wait", {mem_req, busy}, 2'b01);
        mem_rvalid = 1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        mem_rvalid = 0;
        check("flgnt_no_resp", {ld_resp_valid, busy}, 2'b00);

        // Flush never touches a store
        st_valid = 1; st_addr = 32'h800; st_data = 32'h7777_8888; st_size = 2'b10;
        @(negedge clk);
        st_valid = 0; flush = 1;
        @(negedge clk);
        check("flst_req_held", {mem_req, mem_we}, 2'b11);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 1;
        @(negedge clk);
        mem_rvalid = 0; flush = 0;
        check("flst_done", st_done, 1);
        exp_st++;

        // Delayed grant: request fields stay put while the LSQ inputs change
        @(negedge clk);
        st_valid = 1; st_addr = 32'hA0; st_data = 32'h1234_5678; st_size = 2'b01;
        @(negedge clk);
        st_valid = 0; st_addr = 32'hFFFF_FFF0; st_data = 32'h0; st_size = 2'b10;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d_req", i), {mem_req, mem_we, mem_size, mem_addr}, {1'b1, 1'b1, 2'b01, 32'hA0});
            check($sformatf("hold%0d_wdata", i), mem_wdata, 32'h1234_5678);
            @(negedge clk);
        end
        serve(0, 32'h0);
        check("hold_st_done", st_done, 1);
        exp_st++;

        // A normal load after the kills returns data
        ld_valid = 1; ld_addr = 32'h900; ld_tag = 6'd33; ld_size = 2'b00;
        @(negedge clk);
        ld_valid = 0;
        check("post_kill_size", mem_size, 2'b00);
        serve(2, 32'h0000_00AB);
        check("post_kill_resp", {ld_resp_valid, ld_resp_tag, ld_resp_data}, {1'b1, 6'd33, 32'h0000_00AB});
        exp_ld++;

`ifdef SCHED_PERF_CNT_EN
        check("perf_ld_cnt", perf_ld_cnt, 64'(exp_ld));
        check("perf_st_cnt", perf_st_cnt, 64'(exp_st));
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
